// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down timer with per-digit rollover limits, start/pause/load control,
// clamped preset loading, optional auto-reload and a one-cycle done pulse at terminal count.
module bcd_updown_timer #(
  parameter int                        NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]   LIMITS     = 16'h5959,
  parameter logic [4*NUM_DIGITS-1:0]   INIT_VALUE = 16'h0100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    up,
  input  logic                    auto_reload,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    running,
  output logic                    expired,
  output logic                    done,
  output logic                    zero
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t               state_reg;
  logic [W-1:0]         value_reg;
  logic [W-1:0]         preset_reg;
  logic                 done_reg;

  logic [W-1:0]          clamped_value;
  logic [W-1:0]          up_value;
  logic [W-1:0]          down_value;
  logic [W-1:0]          step_value;
  logic [NUM_DIGITS-1:0] at_limit;
  logic [NUM_DIGITS-1:0] at_zero;
  logic                  cur_terminal;
  logic                  step_terminal;
  logic                  preset_terminal;

  // A digit moves only when every lower digit sits at its wrap point, so the
  // whole ripple resolves in one cycle without a chained carry net.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] lim;
      logic [3:0] ld;
      logic       carry_in;
      logic       borrow_in;

      assign digit = value_reg[4*gi +: 4];
      assign lim   = LIMITS[4*gi +: 4];
      assign ld    = load_value[4*gi +: 4];

      assign at_limit[gi] = (digit == lim);
      assign at_zero[gi]  = (digit == 4'd0);

      if (gi == 0) begin : g_lsd
        assign carry_in  = 1'b1;
        assign borrow_in = 1'b1;
      end else begin : g_upper
        assign carry_in  = &at_limit[gi-1:0];
        assign borrow_in = &at_zero[gi-1:0];
      end

      assign up_value[4*gi +: 4]   = !carry_in  ? digit : (at_limit[gi] ? 4'd0 : digit + 4'd1);
      assign down_value[4*gi +: 4] = !borrow_in ? digit : (at_zero[gi]  ? lim  : digit - 4'd1);
      assign clamped_value[4*gi +: 4] = (ld > lim) ? lim : ld;
    end
  endgenerate

  assign step_value      = up ? up_value : down_value;
  assign cur_terminal    = up ? (&at_limit) : (&at_zero);
  assign step_terminal   = up ? (step_value == LIMITS) : (step_value == '0);
  assign preset_terminal = up ? (preset_reg == LIMITS) : (preset_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      value_reg  <= INIT_VALUE;
      preset_reg <= INIT_VALUE;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        preset_reg <= clamped_value;
        value_reg  <= clamped_value;
        state_reg  <= IDLE;
      end else begin
        case (state_reg)
          IDLE, PAUSED: begin
            if (start) state_reg <= RUNNING;
          end
          EXPIRED: begin
            if (start) begin
              value_reg <= preset_reg;
              state_reg <= RUNNING;
            end
          end
          RUNNING: begin
            if (pause) begin
              state_reg <= PAUSED;
            end else if (tick) begin
              if (cur_terminal) begin
                // Already terminal: either a preset that starts terminal or an auto-reload wrap.
                if (auto_reload) begin
                  value_reg <= preset_reg;
                  done_reg  <= preset_terminal;
                end else begin
                  state_reg <= EXPIRED;
                  done_reg  <= 1'b1;
                end
              end else begin
                value_reg <= step_value;
                if (step_terminal) begin
                  done_reg <= 1'b1;
                  if (!auto_reload) state_reg <= EXPIRED;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign value   = value_reg;
  assign running = (state_reg == RUNNING);
  assign expired = (state_reg == EXPIRED);
  assign done    = done_reg;
  assign zero    = (value_reg == '0);

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Scoreboard bench for bcd_updown_timer: stimulus queues expected outputs,
// a monitor pops and compares them one cycle after each sampling edge.
module tb_bcd_updown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, pause, load, up, auto_reload;
  logic [15:0] load_value;
  logic [15:0] value;
  logic        running, expired, done, zero;

  typedef struct {
    logic [15:0] v;
    logic        r, e, d, z;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  bcd_updown_timer #(
    .NUM_DIGITS(4),
    .LIMITS    (16'h5959),
    .INIT_VALUE(16'h0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .load       (load),
    .load_value (load_value),
    .up         (up),
    .auto_reload(auto_reload),
    .value      (value),
    .running    (running),
    .expired    (expired),
    .done       (done),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("FAIL %s: got value=%h run/exp/done/zero=%b, expected value=%h run/exp/done/zero=%b",
               nm, act[19:4], act[3:0], exp[19:4], exp[3:0]);
    else begin
      pass_cnt++;
      $display("ok   %s: value=%h run/exp/done/zero=%b", nm, act[19:4], act[3:0]);
    end
  endtask

  function automatic logic [15:0] bcd2(input int n);
    logic [3:0] tens, ones;
    tens = 4'(n / 10);
    ones = 4'(n % 10);
    return {8'h00, tens, ones};
  endfunction

  // One stimulus cycle: drive at the falling edge, queue what must show after the next rising edge.
  task automatic step(input logic t, s, p, l, input logic [15:0] lv, input logic u, ar,
                      input logic [15:0] ev, input logic er, ee, ed, input string nm);
    exp_t x;
    @(negedge clk);
    tick = t; start = s; pause = p; load = l; load_value = lv; up = u; auto_reload = ar;
    x.v = ev; x.r = er; x.e = ee; x.d = ed; x.z = (ev == 16'h0000); x.nm = nm;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check(x.nm, {value, running, expired, done, zero}, {x.v, x.r, x.e, x.d, x.z});
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    tick = 0; start = 0; pause = 0; load = 0; load_value = 16'h0; up = 0; auto_reload = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("reset", {value, running, expired, done, zero}, {16'h0100, 4'b0000});

    // Count down to 0042, then hit reset between clock edges.
    step(0,1,0,0,16'h0,0,0, 16'h0100,1,0,0, "start");
    for (int k = 1; k <= 18; k++)
      step(1,0,0,0,16'h0,0,0, bcd2(60-k),1,0,0, "down_tick");
    step(0,0,0,0,16'h0,0,0, 16'h0042,1,0,0, "hold_0042");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst", {value, running, expired, done, zero}, {16'h0100, 4'b0000});
    @(negedge clk);
    rst = 1'b0;

    // Full 60-tick countdown, done exactly on the last tick, then stuck at 0000.
    step(0,1,0,0,16'h0,0,0, 16'h0100,1,0,0, "start2");
    for (int k = 1; k <= 60; k++)
      step(1,0,0,0,16'h0,0,0, bcd2(60-k), (k < 60), (k == 60), (k == 60), "count60");
    step(1,0,0,0,16'h0,0,0, 16'h0000,0,1,0, "expired_tick1");
    step(1,0,0,0,16'h0,0,0, 16'h0000,0,1,0, "expired_tick2");
    step(0,1,0,0,16'h0,0,0, 16'h0100,1,0,0, "restart_from_expired");
    step(1,0,0,1,16'h0230,0,0, 16'h0230,0,0,0, "load_beats_tick");
    step(0,0,0,1,16'h0A7F,0,0, 16'h0959,0,0,0, "load_clamp");

    // Up count with auto-reload.
    step(0,0,0,1,16'h5958,1,1, 16'h5958,0,0,0, "load_5958");
    step(0,1,0,0,16'h0,1,1, 16'h5958,1,0,0, "start_up");
    step(1,0,0,0,16'h0,1,1, 16'h5959,1,0,1, "up_terminal");
    step(1,0,0,0,16'h0,1,1, 16'h5958,1,0,0, "auto_reload_wrap");

    // Pause/start interactions.
    step(1,0,1,0,16'h0,1,1, 16'h5958,0,0,0, "pause_beats_tick");
    step(0,1,1,0,16'h0,1,1, 16'h5958,1,0,0, "paused_start_wins");
    step(0,1,1,0,16'h0,1,1, 16'h5958,0,0,0, "running_pause_wins");
    step(1,1,0,0,16'h0,1,1, 16'h5958,1,0,0, "start_tick_ignored");

    // Preset that is already terminal.
    step(0,0,0,1,16'h0000,0,1, 16'h0000,0,0,0, "load_zero");
    step(0,1,0,0,16'h0,0,1, 16'h0000,1,0,0, "start_zero");
    step(1,0,0,0,16'h0,0,1, 16'h0000,1,0,1, "terminal_preset_reload");
    step(1,0,0,0,16'h0,0,0, 16'h0000,0,1,1, "terminal_preset_expire");
    step(1,0,0,0,16'h0,0,0, 16'h0000,0,1,0, "no_wrap_past_terminal");

    // Direction change mid-run.
    step(0,0,0,1,16'h0100,0,0, 16'h0100,0,0,0, "load_0100");
    step(0,1,0,0,16'h0,0,0, 16'h0100,1,0,0, "start_dir");
    step(1,0,0,0,16'h0,0,0, 16'h0059,1,0,0, "dir_down");
    step(1,0,0,0,16'h0,1,0, 16'h0100,1,0,0, "dir_up");
    step(1,0,0,0,16'h0,1,0, 16'h0101,1,0,0, "dir_up2");
    step(0,0,0,0,16'h0,1,0, 16'h0101,1,0,0, "idle_end");

    repeat (3) @(posedge clk);
    #2;
    check_cnt++;
    if (q.size() != 0)
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    else
      pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
